// File: rtl/intpol2_d4_ctrl_pkg.sv
// Shared encodings for the quadratic-interpolation controller: FSM states and
// the xi/xi^2 generator step selects.
package intpol2_d4_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_P0    = 3'd1,
      ST_P1    = 3'd2,
      ST_P2    = 3'd3,
      ST_COEF  = 3'd4,
      ST_MUL1  = 3'd5,
      ST_MUL2  = 3'd6,
      ST_FETCH = 3'd7
   } state_e;

   localparam logic [1:0] SEL_XI2_LOAD = 2'd0;
   localparam logic [1:0] SEL_XI2_INC  = 2'd1;
   localparam logic [1:0] SEL_XI2_HOLD = 2'd2;

endpackage

// File: rtl/intpol2_d4_ctrl.sv
// Sequencer for the quadratic-interpolation datapath: primes the sample window,
// strobes coefficients, then emits N results per input interval over a shared multiplier.
module intpol2_d4_ctrl
   import intpol2_d4_ctrl_pkg::*;
#(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             stop,
   input  logic [CNT_W-1:0] cfg_n,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             clear,
   output logic             Ld_M0,
   output logic             Ld_M1,
   output logic             Ld_M2,
   output logic             en_stream,
   output logic             op_1,
   output logic             Ld_p1_xi,
   output logic             sel_mult,
   output logic             en_sum,
   output logic [1:0]       sel_xi2,
   output logic             Ld_y
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] n_q, n_d;
   logic             stop_pend_q, stop_pend_d;
   logic             stop_any;
   logic             is_last;

   // A stop seen this very cycle counts as already pending.
   assign stop_any = stop_pend_q | stop;
   assign is_last  = (cnt_q == (n_q - ONE));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         n_q         <= ONE;
         stop_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         n_q         <= n_d;
         stop_pend_q <= stop_pend_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      n_d         = n_q;
      stop_pend_d = stop_pend_q;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      clear       = 1'b0;
      Ld_M0       = 1'b0;
      Ld_M1       = 1'b0;
      Ld_M2       = 1'b0;
      en_stream   = 1'b0;
      op_1        = 1'b0;
      Ld_p1_xi    = 1'b0;
      sel_mult    = 1'b0;
      en_sum      = 1'b0;
      sel_xi2     = SEL_XI2_HOLD;
      busy        = (state_q != ST_IDLE);

      if ((state_q != ST_IDLE) && stop) begin
         stop_pend_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               n_d     = (cfg_n == '0) ? ONE : cfg_n;
               state_d = ST_P0;
            end
         end
         ST_P0: begin
            in_ready = 1'b1;
            if (in_valid) begin
               Ld_M0   = 1'b1;
               state_d = stop_any ? ST_IDLE : ST_P1;
            end
         end
         ST_P1: begin
            in_ready = 1'b1;
            if (in_valid) begin
               Ld_M1   = 1'b1;
               state_d = stop_any ? ST_IDLE : ST_P2;
            end
         end
         ST_P2: begin
            in_ready = 1'b1;
            if (in_valid) begin
               Ld_M2   = 1'b1;
               clear   = 1'b1;
               state_d = stop_any ? ST_IDLE : ST_COEF;
            end
         end
         ST_COEF: begin
            op_1    = 1'b1;
            state_d = ST_MUL1;
         end
         ST_MUL1: begin
            Ld_p1_xi = 1'b1;
            state_d  = ST_MUL2;
         end
         ST_MUL2: begin
            sel_mult  = 1'b1;
            out_valid = 1'b1;
            // Without out_ready everything stays frozen so the result holds.
            if (out_ready) begin
               if (!is_last) begin
                  en_sum  = 1'b1;
                  sel_xi2 = (cnt_q == '0) ? SEL_XI2_LOAD : SEL_XI2_INC;
                  cnt_d   = cnt_q + ONE;
                  state_d = ST_MUL1;
               end else begin
                  cnt_d   = '0;
                  state_d = stop_any ? ST_IDLE : ST_FETCH;
               end
            end
         end
         ST_FETCH: begin
            in_ready = 1'b1;
            if (in_valid) begin
               en_stream = 1'b1;
               clear     = 1'b1;
               state_d   = ST_COEF;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_IDLE) begin
         stop_pend_d = 1'b0;
      end
   end

   assign Ld_y = out_valid;

endmodule

// File: tb/tb_intpol2_d4_ctrl.sv
// Randomized bench for intpol2_d4_ctrl: a queue of expected run steps (window priming,
// coefficient strobe, N multiply/result pairs, fetch) predicts every control output each cycle.
module tb_intpol2_d4_ctrl;

   localparam int CNT_W = 6;

   localparam int K_M0    = 0;
   localparam int K_M1    = 1;
   localparam int K_M2    = 2;
   localparam int K_COEF  = 3;
   localparam int K_MUL1  = 4;
   localparam int K_RES   = 5;
   localparam int K_FETCH = 6;

   typedef struct {
      int kind;
      int idx;
   } step_t;

   logic             clk = 1'b0;
   logic             rstn;
   logic             start;
   logic             stop;
   logic [CNT_W-1:0] cfg_n;
   logic             in_valid;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             clear;
   logic             Ld_M0, Ld_M1, Ld_M2;
   logic             en_stream;
   logic             op_1;
   logic             Ld_p1_xi;
   logic             sel_mult;
   logic             en_sum;
   logic [1:0]       sel_xi2;
   logic             Ld_y;
   logic [14:0]      obs;

   int total = 0;
   int bad   = 0;

   // Expected remaining steps of the current run; empty means idle.
   step_t q[$];
   int    n_lat = 1;
   bit    stopf = 1'b0;

   int iv_pct, or_pct, n_mode, stop_div;

   intpol2_d4_ctrl #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start),
      .stop      (stop),
      .cfg_n     (cfg_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .clear     (clear),
      .Ld_M0     (Ld_M0),
      .Ld_M1     (Ld_M1),
      .Ld_M2     (Ld_M2),
      .en_stream (en_stream),
      .op_1      (op_1),
      .Ld_p1_xi  (Ld_p1_xi),
      .sel_mult  (sel_mult),
      .en_sum    (en_sum),
      .sel_xi2   (sel_xi2),
      .Ld_y      (Ld_y)
   );

   always #5 clk = ~clk;

   assign obs = {busy, in_ready, out_valid, clear, Ld_M0, Ld_M1, Ld_M2, en_stream,
                 op_1, Ld_p1_xi, sel_mult, en_sum, sel_xi2, Ld_y};

   task automatic check(input string tag, input logic [14:0] o, input logic [14:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   function automatic logic [14:0] model_out(input logic iv, input logic ordy);
      logic bsy = 1'b0, ir = 1'b0, ov = 1'b0, clr = 1'b0;
      logic m0 = 1'b0, m1 = 1'b0, m2 = 1'b0, es = 1'b0;
      logic op = 1'b0, lp = 1'b0, sm = 1'b0, esum = 1'b0;
      logic [1:0] sx = 2'd2;
      if (q.size() != 0) begin
         bsy = 1'b1;
         case (q[0].kind)
            K_M0:    begin ir = 1'b1; m0 = iv; end
            K_M1:    begin ir = 1'b1; m1 = iv; end
            K_M2:    begin ir = 1'b1; m2 = iv; clr = iv; end
            K_COEF:  op = 1'b1;
            K_MUL1:  lp = 1'b1;
            K_RES: begin
               ov = 1'b1;
               sm = 1'b1;
               if (ordy && (q[0].idx < n_lat - 1)) begin
                  esum = 1'b1;
                  sx   = (q[0].idx == 0) ? 2'd0 : 2'd1;
               end
            end
            K_FETCH: begin ir = 1'b1; es = iv; clr = iv; end
            default: ;
         endcase
      end
      return {bsy, ir, ov, clr, m0, m1, m2, es, op, lp, sm, esum, sx, ov};
   endfunction

   function automatic void push_interval();
      q.push_back('{K_COEF, 0});
      for (int i = 0; i < n_lat; i++) begin
         q.push_back('{K_MUL1, i});
         q.push_back('{K_RES, i});
      end
      q.push_back('{K_FETCH, 0});
   endfunction

   // Advance the expected run by one clock, given the inputs that clock saw.
   function automatic void model_step();
      step_t h;
      if (q.size() == 0) begin
         if (start) begin
            n_lat = (cfg_n == 0) ? 1 : int'(cfg_n);
            q.push_back('{K_M0, 0});
            q.push_back('{K_M1, 0});
            q.push_back('{K_M2, 0});
            push_interval();
         end
         return;
      end
      if (stop) stopf = 1'b1;
      h = q[0];
      case (h.kind)
         K_M0, K_M1, K_M2: begin
            if (in_valid) begin
               void'(q.pop_front());
               if (stopf) begin
                  q.delete();
                  stopf = 1'b0;
               end
            end
         end
         K_COEF, K_MUL1: void'(q.pop_front());
         K_RES: begin
            if (out_ready) begin
               void'(q.pop_front());
               if ((h.idx == n_lat - 1) && stopf) begin
                  q.delete();
                  stopf = 1'b0;
               end
            end
         end
         K_FETCH: begin
            if (in_valid) begin
               void'(q.pop_front());
               push_interval();
            end
         end
         default: ;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] pick_n();
      case (n_mode)
         0:       return CNT_W'($urandom_range(0, 5));
         1:       return CNT_W'(4);
         2:       return CNT_W'($urandom_range(0, 1));
         default: return CNT_W'($urandom_range(0, 63));
      endcase
   endfunction

   task automatic cycle(input string tag);
      @(negedge clk);
      start     = ($urandom_range(0, 5) == 0);
      stop      = ($urandom_range(0, stop_div - 1) == 0);
      cfg_n     = pick_n();
      in_valid  = ($urandom_range(0, 99) < iv_pct);
      out_ready = ($urandom_range(0, 99) < or_pct);
      #1;
      check(tag, obs, model_out(in_valid, out_ready));
      @(posedge clk);
      model_step();
   endtask

   initial begin
      int guard;
      rstn      = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      cfg_n     = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      q.delete();
      check("reset_state", obs, model_out(1'b0, 1'b0));
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check("after_reset", obs, model_out(1'b0, 1'b0));

      // Mostly flowing traffic, small N.
      iv_pct = 90; or_pct = 90; n_mode = 0; stop_div = 200;
      for (int k = 0; k < 800; k++) cycle("flow");

      // N = 4 with heavy stalls on both sides.
      iv_pct = 30; or_pct = 30; n_mode = 1; stop_div = 150;
      for (int k = 0; k < 800; k++) cycle("stall_n4");

      // N = 0 / 1: one result per sample, generators never stepped.
      iv_pct = 80; or_pct = 80; n_mode = 2; stop_div = 120;
      for (int k = 0; k < 600; k++) cycle("n01");

      // Asynchronous reset while a result is being presented.
      iv_pct = 95; or_pct = 95; n_mode = 1; stop_div = 100000;
      guard = 0;
      while (!((q.size() != 0) && (q[0].kind == K_RES)) && (guard < 500)) begin
         cycle("seek_mul2");
         guard++;
      end
      @(negedge clk);
      start = 1'b0; stop = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      check("rst_ov_high", {14'b0, out_valid}, 15'd1);
      check("pre_rst", obs, model_out(1'b0, 1'b0));
      rstn = 1'b0;
      #1;
      q.delete();
      stopf = 1'b0;
      check("rst_mid_run", obs, model_out(1'b0, 1'b0));
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check("post_rst_idle", obs, model_out(1'b0, 1'b0));

      // Wide N range with frequent stop pulses.
      iv_pct = 75; or_pct = 75; n_mode = 3; stop_div = 40;
      for (int k = 0; k < 2000; k++) cycle("wide_stop");

      // Plain traffic again to confirm recovery.
      iv_pct = 85; or_pct = 85; n_mode = 0; stop_div = 300;
      for (int k = 0; k < 500; k++) cycle("tail");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
